// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state encoding and byte width shared by the UART TX arbiter files
package uart_tx_arbiter_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker; req mask + rr_ptr in, hit + idx of first set bit at/after ptr (wrapping) out
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            hit,
  output logic [IDW-1:0]  idx
);
  logic [NREQ-1:0] rot;
  assign rot = NREQ'({req, req} >> ptr);
  assign hit = |req;
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) idx = IDW'((k + int'(ptr)) % NREQ);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX among NREQ sources with grant lock; ports sys_clk/sys_rst, req_valid/req_lock/req_data/req_ack, tx_data/tx_wr/tx_done, grant_id/busy/err_timeout; macro UART_TX_ARBITER_TIMEOUT_EN enables the tx_done watchdog
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 2 ** 20
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_lock,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]             req_ack,
  output logic [UART_BYTE_W-1:0]      tx_data,
  output logic                        tx_wr,
  input  logic                        tx_done,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic                        err_timeout
);
  state_t state, state_nxt;
  logic locked, locked_nxt, pick_hit, hold, arb, serve, wd_hit;
  logic [IDW-1:0] rr_ptr, rr_nxt, pick_idx, sel_idx, gid_nxt;
  uart_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .hit(pick_hit),
    .idx(pick_idx)
  );
  // An arbitration slot exists in IDLE and in the tx_done cycle, so a waiting byte goes out the very next cycle.
  // The lock survives only while the owner still has a byte or still asserts req_lock.
  assign arb     = state == ST_IDLE || tx_done;
  assign hold    = locked && (req_valid[grant_id] || req_lock[grant_id]);
  assign sel_idx = hold ? grant_id : pick_idx;
  assign serve   = arb && (hold ? req_valid[grant_id] : pick_hit);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state    <= ST_IDLE;
      locked   <= 1'b0;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_wr    <= 1'b0;
      tx_data  <= '0;
      req_ack  <= '0;
    end else begin
      state    <= state_nxt;
      locked   <= locked_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= gid_nxt;
      busy     <= state_nxt == ST_BUSY;
      tx_wr    <= serve;
      tx_data  <= serve ? req_data[UART_BYTE_W*sel_idx +: UART_BYTE_W] : tx_data;
      req_ack  <= serve ? NREQ'(1) << sel_idx : '0;
    end
  always_comb
    state_nxt = serve ? ST_BUSY : (tx_done || wd_hit) ? ST_IDLE : state;
  always_comb begin
    locked_nxt = serve ? req_lock[sel_idx] : ((arb && !hold) || wd_hit) ? 1'b0 : locked;
    rr_nxt     = serve ? IDW'((int'(sel_idx) + 1) % NREQ) : rr_ptr;
    gid_nxt    = serve ? sel_idx : grant_id;
  end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  assign wd_hit = state == ST_BUSY && !tx_done && wd_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= (serve || state != ST_BUSY) ? '0 : wd_cnt + 1'b1;
      err_timeout <= wd_hit;
    end
`else
  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with a 20-cycle transmitter model
module tb_uart_tx_arbiter;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_lock = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  int n_chk = 0;
  int n_fail = 0;
  int wr_count = 0;
  int wr_viol = 0;
  bit in_flight = 1'b0;
  uart_tx_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(64)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req_valid(req_valid),
    .req_lock(req_lock),
    .req_data(req_data),
    .req_ack(req_ack),
    .tx_data(tx_data),
    .tx_wr(tx_wr),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .err_timeout(err_timeout)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    if (tx_wr && in_flight) wr_viol++;
    if (tx_wr) wr_count++;
    in_flight = !sys_rst && (tx_wr || (in_flight && !tx_done && !err_timeout));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic do_reset();
    sys_rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    tx_done = 1'b0;
    step(2);
    sys_rst = 1'b0;
  endtask
  task automatic wait_wr(input string tag);
    int n = 0;
    while (!tx_wr && n < 64) begin
      step();
      n++;
    end
    check({tag, "_wr"}, 32'(tx_wr), 32'd1);
  endtask
  task automatic expect_grant(input string tag, input int id, input logic [7:0] d);
    wait_wr(tag);
    check({tag, "_gid"}, 32'(grant_id), 32'(id));
    check({tag, "_ack"}, 32'(req_ack), 32'(1 << id));
    check({tag, "_data"}, 32'(tx_data), 32'(d));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask
  task automatic finish_byte();
    step(20);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask
  initial begin
    int w0;
    int n;
    bit seen;
    do_reset();
    check("rst_ack", 32'(req_ack), 0);
    check("rst_wr", 32'(tx_wr), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);
    w0 = wr_count;
    req_data[15:8] = 8'h41;
    req_valid = 4'b0010;
    step();
    check("single_lat", 32'(tx_wr), 1);
    expect_grant("single", 1, 8'h41);
    req_valid = '0;
    step();
    check("single_ack_pulse", 32'(req_ack), 0);
    check("single_wr_pulse", 32'(tx_wr), 0);
    check("single_busy_hold", 32'(busy), 1);
    finish_byte();
    check("single_idle", 32'(busy), 0);
    step(5);
    check("single_wr_count", 32'(wr_count - w0), 1);
    do_reset();
    req_data = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_grant($sformatf("rr%0d", i), i % 4, 8'hA0 + 8'(i % 4));
      if (i == 4) req_valid = '0;
      finish_byte();
      if (i < 4) check($sformatf("rr%0d_b2b", i), 32'(tx_wr), 1);
    end
    do_reset();
    req_data = 32'h00C0000F;
    req_lock = 4'b0100;
    req_valid = 4'b0100;
    expect_grant("lock0", 2, 8'hC0);
    req_valid = 4'b0101;
    req_data[23:16] = 8'hC1;
    finish_byte();
    expect_grant("lock1", 2, 8'hC1);
    req_data[23:16] = 8'hC2;
    req_lock = '0;
    finish_byte();
    expect_grant("lock2", 2, 8'hC2);
    req_valid = 4'b0001;
    finish_byte();
    expect_grant("lock_then0", 0, 8'h0F);
    req_valid = '0;
    finish_byte();
    do_reset();
    req_data = 32'h33000011;
    req_data[15:8] = 8'h11;
    req_lock = 4'b0010;
    req_valid = 4'b0010;
    expect_grant("hold", 1, 8'h11);
    req_valid = 4'b1000;
    finish_byte();
    check("hold_blocked_wr", 32'(tx_wr), 0);
    check("hold_blocked_busy", 32'(busy), 0);
    step(3);
    check("hold_still_blocked", 32'(tx_wr), 0);
    req_lock = '0;
    step();
    check("release_same_cycle", 32'(tx_wr), 1);
    expect_grant("release", 3, 8'h33);
    req_valid = '0;
    finish_byte();
    do_reset();
    req_data = 32'h335A0000;
    req_valid = 4'b0100;
    expect_grant("b2b_first", 2, 8'h5A);
    req_valid = '0;
    step(20);
    tx_done = 1'b1;
    req_valid = 4'b1000;
    step();
    tx_done = 1'b0;
    check("b2b_lat", 32'(tx_wr), 1);
    check("b2b_gid", 32'(grant_id), 3);
    check("b2b_data", 32'(tx_data), 32'h33);
    req_valid = '0;
    finish_byte();
    do_reset();
    req_data = 32'h00990000;
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    expect_grant("midrst", 1, 8'h77);
    req_valid = '0;
    step(5);
    sys_rst = 1'b1;
    step();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_gid", 32'(grant_id), 0);
    check("midrst_data", 32'(tx_data), 0);
    check("midrst_wr", 32'(tx_wr), 0);
    check("midrst_ack", 32'(req_ack), 0);
    sys_rst = 1'b0;
    step(3);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("late_done_busy", 32'(busy), 0);
    check("late_done_wr", 32'(tx_wr), 0);
    req_valid = 4'b0100;
    step();
    expect_grant("after_rst", 2, 8'h99);
    req_valid = '0;
    finish_byte();
    do_reset();
    req_data = 32'h00550001;
    req_valid = 4'b0001;
    expect_grant("wd", 0, 8'h01);
    req_valid = '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    check("wd_latency", 32'(n), 64);
    check("wd_busy", 32'(busy), 0);
    req_valid = 4'b0100;
    step();
    check("wd_err_pulse", 32'(err_timeout), 0);
    expect_grant("wd_next", 2, 8'h55);
    req_valid = '0;
    finish_byte();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen |= err_timeout;
    end
    check("wd_off_err", 32'(seen), 0);
    check("wd_off_busy", 32'(busy), 1);
    finish_byte();
    check("wd_off_done", 32'(busy), 0);
`endif
    step(3);
    check("no_wr_in_flight", 32'(wr_viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
